// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcode-class constants used by
// both the fetch unit and the ID controller, and the fetch FSM encoding.
package cpu_pkg;

  localparam int INSTR_W = 32;

  // Opcode class lives in instr[31:29]
  localparam logic [2:0] OPC_RTYPE  = 3'b010;
  localparam logic [2:0] OPC_BRANCH = 3'b100;
  localparam logic [2:0] OPC_ITYPE  = 3'b110;
  localparam logic [2:0] OPC_MEM    = 3'b111;

  typedef enum logic [1:0] {
    FETCH_READY = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DROP  = 2'd2
  } fetch_state_e;

  function automatic logic is_branch(input logic [INSTR_W-1:0] instr);
    return instr[31:29] == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC register and next-PC selection: reset value, redirect target,
// or sequential increment from the PC of the instruction just returned.
module if_pc_gen
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  input  logic [31:0] adv_base,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  // Redirect beats sequential advance; arithmetic wraps modulo 2^32
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = adv_base + PC_STEP;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: single-outstanding fetch FSM plus a one-entry
// valid/ready output register towards decode. Redirects flush both.
// Optional build macro IF_BRANCH_STALL_EN: hold fetch after a branch-class
// instruction until redirect_valid or branch_done.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               branch_done,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  input  logic               id_ready
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [31:0]        id_pc_q, id_pc_d;
  logic [31:0]        pc;
  logic               slot_free;
  logic               branch_hold;
  logic               issue;
  logic               load;

`ifdef IF_BRANCH_STALL_EN
  logic hold_q, hold_d;
  assign branch_hold = hold_q;
`else
  logic unused_branch_done;
  assign unused_branch_done = branch_done;
  assign branch_hold        = 1'b0;
`endif

  // Memory cannot be stalled, so only request when the response has a home
  assign slot_free = !id_valid_q || id_ready;
  assign issue     = (state_q == FETCH_READY) && slot_free && !redirect_valid && !branch_hold;
  assign load      = (state_q == FETCH_WAIT) && imem_rvalid && !redirect_valid;

  if_pc_gen #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (load),
    .adv_base       (req_pc_q),
    .pc             (pc)
  );

  // Next-state for the fetch FSM, output register and branch hold
  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;

    case (state_q)
      FETCH_READY: begin
        if (issue) begin
          req_pc_d = pc;
          state_d  = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH_READY;
        end else if (redirect_valid) begin
          state_d = FETCH_DROP;
        end
      end
      FETCH_DROP: begin
        if (imem_rvalid) begin
          state_d = FETCH_READY;
        end
      end
      default: state_d = FETCH_READY;
    endcase

    if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end
    if (load) begin
      id_valid_d = 1'b1;
      id_instr_d = imem_rdata;
      id_pc_d    = req_pc_q;
    end
    if (redirect_valid) begin
      id_valid_d = 1'b0;
    end

`ifdef IF_BRANCH_STALL_EN
    hold_d = hold_q;
    if (redirect_valid || branch_done) begin
      hold_d = 1'b0;
    end
    if (load && is_branch(imem_rdata)) begin
      hold_d = 1'b1;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_READY;
      req_pc_q   <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
`ifdef IF_BRANCH_STALL_EN
      hold_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
`ifdef IF_BRANCH_STALL_EN
      hold_q     <= hold_d;
`endif
    end
  end

  // Request is a same-cycle decision; suppressed while reset is held
  assign imem_req  = issue && rst_n;
  assign imem_addr = pc;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;

endmodule
